reg_file_write_arbiter: RTL and testbench

- Shares the register file's NUM_WRITE_PORTS physical write ports among NUM_REQ writeback requesters (ALU, FPU, LSU, ...).
- Requesters use a valid/ready handshake. Each cycle the block picks up to NUM_WRITE_PORTS requests in round-robin order and drives them onto registered write ports.
- Guarantees no two write ports target the same physical register in one cycle, which the register file requires.
- Ages waiting requesters so that none starves.

---
 rtl/reg_file_write_arbiter_if.sv | 28 ++
 rtl/reg_file_write_arbiter.sv | 144 ++++++++++++++
 tb/tb_reg_file_write_arbiter.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_write_arbiter_if.sv
// Writeback requester handshake and register-file write-port bus shared by the write arbiter.
interface reg_file_write_arbiter_if #(
    parameter int WORD_SIZE       = 64,
    parameter int NUM_PHYS_REGS   = 64,
    parameter int NUM_REQ         = 4,
    parameter int NUM_WRITE_PORTS = 2
);
    localparam int PREG_W = $clog2(NUM_PHYS_REGS);

    logic [NUM_REQ-1:0]                        req_valid;
    logic [NUM_REQ-1:0][PREG_W-1:0]            req_preg;
    logic [NUM_REQ-1:0][WORD_SIZE-1:0]         req_data;
    logic [NUM_REQ-1:0]                        req_ready;
    logic [NUM_WRITE_PORTS-1:0]                wr_en;
    logic [NUM_WRITE_PORTS-1:0][PREG_W-1:0]    wr_preg;
    logic [NUM_WRITE_PORTS-1:0][WORD_SIZE-1:0] wr_data;
    logic [NUM_REQ-1:0]                        starved;

    modport master (
        output req_valid, req_preg, req_data,
        input  req_ready, wr_en, wr_preg, wr_data, starved
    );

    modport slave (
        input  req_valid, req_preg, req_data,
        output req_ready, wr_en, wr_preg, wr_data, starved
    );
endinterface

// File: rtl/reg_file_write_arbiter.sv
// Round-robin arbiter sharing the register file write ports among writeback requesters,
// with same-register conflict avoidance and starvation-forced priority.
module reg_file_write_arbiter #(
    parameter int WORD_SIZE       = 64,
    parameter int NUM_PHYS_REGS   = 64,
    parameter int NUM_REQ         = 4,
    parameter int NUM_WRITE_PORTS = 2,
    parameter int STARVE_LIMIT    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    reg_file_write_arbiter_if.slave bus
);
    localparam int PREG_W = $clog2(NUM_PHYS_REGS);
    localparam int REQ_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);

    logic                                      run_p0;
    logic [REQ_W-1:0]                          rr_ptr_p0;
    logic [NUM_REQ-1:0][CNT_W-1:0]             starve_cnt_p0;
    logic [NUM_REQ-1:0]                        starved_p0;
    logic [NUM_WRITE_PORTS-1:0]                wr_en_p1;
    logic [NUM_WRITE_PORTS-1:0][PREG_W-1:0]    wr_preg_p1;
    logic [NUM_WRITE_PORTS-1:0][WORD_SIZE-1:0] wr_data_p1;

    logic [NUM_REQ-1:0]                        grant;
    logic [NUM_WRITE_PORTS-1:0]                port_vld;
    logic [NUM_WRITE_PORTS-1:0][REQ_W-1:0]     port_src;
    logic [REQ_W-1:0]                          last_idx;
    logic                                      has_starved;
    logic [REQ_W-1:0]                          starve_idx;
    logic [NUM_REQ-1:0][CNT_W-1:0]             cnt_next;

    function automatic logic [REQ_W-1:0] wrap_idx(input int v);
        return REQ_W'(v % NUM_REQ);
    endfunction

    function automatic logic [REQ_W-1:0] next_ptr(input logic [REQ_W-1:0] idx);
        return (idx == REQ_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == CNT_W'(STARVE_LIMIT)) ? cnt : cnt + 1'b1;
    endfunction

    // Lowest-index starved requester jumps ahead of the round-robin order
    always_comb begin
        has_starved = 1'b0;
        starve_idx  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (starved_p0[i]) begin
                has_starved = 1'b1;
                starve_idx  = REQ_W'(i);
            end
        end
    end

    // Stage p0: scan slot 0 is the starved requester, slots 1..NUM_REQ walk from rr_ptr
    always_comb begin
        logic [REQ_W-1:0] cand;
        logic             eligible;
        logic             clash;
        int               n_grant;
        grant    = '0;
        port_vld = '0;
        port_src = '0;
        last_idx = rr_ptr_p0;
        cand     = '0;
        eligible = 1'b0;
        clash    = 1'b0;
        n_grant  = 0;
        for (int s = 0; s <= NUM_REQ; s++) begin
            if (s == 0) begin
                cand     = starve_idx;
                eligible = has_starved;
            end else begin
                cand     = wrap_idx(int'(rr_ptr_p0) + s - 1);
                eligible = !(has_starved && cand == starve_idx);
            end
            clash = 1'b0;
            for (int k = 0; k < NUM_WRITE_PORTS; k++) begin
                if (port_vld[k] && bus.req_preg[port_src[k]] == bus.req_preg[cand])
                    clash = 1'b1;
            end
            if (run_p0 && eligible && bus.req_valid[cand] && !clash && n_grant < NUM_WRITE_PORTS) begin
                grant[cand] = 1'b1;
                for (int k = 0; k < NUM_WRITE_PORTS; k++) begin
                    if (k == n_grant) begin
                        port_vld[k] = 1'b1;
                        port_src[k] = cand;
                    end
                end
                last_idx = cand;
                n_grant  = n_grant + 1;
            end
        end
    end

    always_comb begin
        cnt_next = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!bus.req_valid[i] || grant[i])
                cnt_next[i] = '0;
            else
                cnt_next[i] = sat_inc(starve_cnt_p0[i]);
        end
    end

    // Stage p1: registered write ports; run_p0 samples reset release on clk
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_p0        <= 1'b0;
            rr_ptr_p0     <= '0;
            starve_cnt_p0 <= '0;
            starved_p0    <= '0;
            wr_en_p1      <= '0;
            wr_preg_p1    <= '0;
            wr_data_p1    <= '0;
        end else begin
            run_p0 <= 1'b1;
            if (|grant)
                rr_ptr_p0 <= next_ptr(last_idx);
            if (run_p0) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    starve_cnt_p0[i] <= cnt_next[i];
                    starved_p0[i]    <= (cnt_next[i] == CNT_W'(STARVE_LIMIT));
                end
            end
            for (int k = 0; k < NUM_WRITE_PORTS; k++) begin
                wr_en_p1[k] <= port_vld[k];
                if (port_vld[k]) begin
                    wr_preg_p1[k] <= bus.req_preg[port_src[k]];
                    wr_data_p1[k] <= bus.req_data[port_src[k]];
                end
            end
        end
    end

    assign bus.req_ready = grant;
    assign bus.wr_en     = wr_en_p1;
    assign bus.wr_preg   = wr_preg_p1;
    assign bus.wr_data   = wr_data_p1;
    assign bus.starved   = starved_p0;
endmodule

// File: tb/tb_reg_file_write_arbiter.sv
// Scoreboard bench for reg_file_write_arbiter: a behavioural model predicts grants and write ports.
module tb_reg_file_write_arbiter;
    localparam int WS    = 64;
    localparam int NPR   = 64;
    localparam int NREQ  = 4;
    localparam int NWP   = 2;
    localparam int LIMIT = 8;
    localparam int PW    = $clog2(NPR);

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    reg_file_write_arbiter_if #(.WORD_SIZE(WS), .NUM_PHYS_REGS(NPR), .NUM_REQ(NREQ),
                                .NUM_WRITE_PORTS(NWP)) bus ();

    reg_file_write_arbiter #(.WORD_SIZE(WS), .NUM_PHYS_REGS(NPR), .NUM_REQ(NREQ),
                             .NUM_WRITE_PORTS(NWP), .STARVE_LIMIT(LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [NREQ-1:0]          valid_in;
    logic [NREQ-1:0][PW-1:0]  preg_in;
    logic [NREQ-1:0][WS-1:0]  data_in;
    assign bus.req_valid = valid_in;
    assign bus.req_preg  = preg_in;
    assign bus.req_data  = data_in;

    int n_checks = 0;
    int n_pass   = 0;

    bit                     m_run;
    int                     m_ptr;
    int                     m_cnt [NREQ];
    logic [NREQ-1:0]        m_starved;
    logic [NREQ-1:0]        m_rdy;
    int                     m_src [NWP];
    int                     m_ngrant;
    int                     m_last;
    logic [NWP-1:0][PW-1:0] m_wpreg;
    logic [NWP-1:0][WS-1:0] m_wdata;

    typedef struct {
        logic [NWP-1:0]         en;
        logic [NWP-1:0][PW-1:0] preg;
        logic [NWP-1:0][WS-1:0] data;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [WS-1:0] got, input logic [WS-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_run = 0; m_ptr = 0; m_starved = '0; m_rdy = '0; m_ngrant = 0; m_last = 0;
        m_wpreg = '0; m_wdata = '0;
        for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
        for (int k = 0; k < NWP; k++) m_src[k] = 0;
    endtask

    task automatic push_zero();
        exp_t z;
        z.en = '0; z.preg = '0; z.data = '0;
        sb.push_back(z);
    endtask

    // Build the scan order as a list, then walk it claiming free, non-conflicting ports
    task automatic model_pick();
        int order[$];
        int used[$];
        int s;
        int n;
        s = -1;
        for (int i = 0; i < NREQ; i++) if (m_starved[i] && s < 0) s = i;
        if (s >= 0) order.push_back(s);
        for (int j = 0; j < NREQ; j++) begin
            int idx;
            idx = (m_ptr + j) % NREQ;
            if (idx != s) order.push_back(idx);
        end
        m_rdy = '0; n = 0; m_last = -1;
        foreach (order[o]) begin
            int c;
            bit dup;
            c = order[o]; dup = 0;
            foreach (used[u]) if (used[u] == int'(preg_in[c])) dup = 1;
            if (m_run && valid_in[c] && n < NWP && !dup) begin
                m_rdy[c] = 1'b1; m_src[n] = c; used.push_back(int'(preg_in[c]));
                n++; m_last = c;
            end
        end
        m_ngrant = n;
    endtask

    task automatic step(output logic [NREQ-1:0] rdy);
        exp_t e;
        @(negedge clk);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("wr_en", WS'(bus.wr_en), WS'(e.en));
            for (int k = 0; k < NWP; k++) begin
                chk($sformatf("wr_preg%0d", k), WS'(bus.wr_preg[k]), WS'(e.preg[k]));
                chk($sformatf("wr_data%0d", k), bus.wr_data[k], e.data[k]);
            end
        end else begin
            chk("sb_nonempty", WS'(0), WS'(1));
        end
        model_pick();
        rdy = bus.req_ready;
        chk("req_ready", WS'(bus.req_ready), WS'(m_rdy));
        chk("starved", WS'(bus.starved), WS'(m_starved));
        e.en = '0;
        for (int k = 0; k < NWP; k++) begin
            if (k < m_ngrant) begin
                e.en[k] = 1'b1;
                m_wpreg[k] = preg_in[m_src[k]];
                m_wdata[k] = data_in[m_src[k]];
            end
        end
        e.preg = m_wpreg; e.data = m_wdata;
        sb.push_back(e);
        @(posedge clk);
        if (m_run) begin
            if (m_ngrant > 0) m_ptr = (m_last + 1) % NREQ;
            for (int i = 0; i < NREQ; i++) begin
                if (!valid_in[i] || m_rdy[i]) m_cnt[i] = 0;
                else if (m_cnt[i] < LIMIT) m_cnt[i]++;
                m_starved[i] = (m_cnt[i] == LIMIT);
            end
        end
        m_run = 1;
        #1;
        chk("no_dup_preg", WS'(bus.wr_en == '1 && bus.wr_preg[0] == bus.wr_preg[1]), WS'(0));
    endtask

    task automatic retire(input logic [NREQ-1:0] r);
        valid_in = valid_in & ~r;
    endtask

    initial begin
        logic [NREQ-1:0] r;
        valid_in = '0; preg_in = '0; data_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_en", WS'(bus.wr_en), WS'(0));
        chk("rst_starved", WS'(bus.starved), WS'(0));
        for (int k = 0; k < NWP; k++) begin
            chk("rst_wr_preg", WS'(bus.wr_preg[k]), WS'(0));
            chk("rst_wr_data", bus.wr_data[k], WS'(0));
        end
        valid_in = '1;
        #1 chk("rst_ready", WS'(bus.req_ready), WS'(0));
        valid_in = '0;
        rst = 1'b1;
        push_zero();

        // Idle after release
        repeat (5) step(r);

        // Four distinct requests drain two per cycle
        valid_in = 4'b1111;
        for (int i = 0; i < NREQ; i++) begin
            preg_in[i] = PW'(5 + i);
            data_in[i] = WS'(64'hA0 + i);
        end
        step(r);
        chk("tp2_ready0", WS'(r), WS'(4'b0011));
        chk("tp2_p0_preg", WS'(bus.wr_preg[0]), WS'(5));
        chk("tp2_p0_data", bus.wr_data[0], WS'(64'hA0));
        chk("tp2_p1_preg", WS'(bus.wr_preg[1]), WS'(6));
        chk("tp2_p1_data", bus.wr_data[1], WS'(64'hA1));
        retire(r);
        step(r);
        chk("tp2_ready1", WS'(r), WS'(4'b1100));
        chk("tp2_wr_en", WS'(bus.wr_en), WS'(2'b11));
        chk("tp2_p0_preg_b", WS'(bus.wr_preg[0]), WS'(7));
        chk("tp2_p1_data_b", bus.wr_data[1], WS'(64'hA3));
        retire(r);
        step(r);

        // Move rr_ptr to 1, then two requesters collide on preg 9
        valid_in = 4'b0001; preg_in[0] = PW'(1); data_in[0] = WS'(64'h11);
        step(r); retire(r);
        valid_in = 4'b0110; preg_in[1] = PW'(9); preg_in[2] = PW'(9);
        data_in[1] = WS'(64'hB1); data_in[2] = WS'(64'hB2);
        step(r);
        chk("tp3_ready0", WS'(r), WS'(4'b0010));
        retire(r);
        step(r);
        chk("tp3_ready1", WS'(r), WS'(4'b0100));
        chk("tp3_wr_en", WS'(bus.wr_en), WS'(2'b01));
        retire(r);

        // Wrap-around: rr_ptr=3 with requesters 3 and 0
        valid_in = 4'b1001; preg_in[3] = PW'(12); preg_in[0] = PW'(13);
        data_in[3] = WS'(64'hC3); data_in[0] = WS'(64'hC0);
        step(r);
        chk("tp4_ready", WS'(r), WS'(4'b1001));
        chk("tp4_port0", bus.wr_data[0], WS'(64'hC3));
        chk("tp4_port1", bus.wr_data[1], WS'(64'hC0));
        retire(r);
        valid_in = 4'b1111;
        for (int i = 0; i < NREQ; i++) begin
            preg_in[i] = PW'(14 + i); data_in[i] = WS'(64'hD0 + i);
        end
        step(r);
        chk("tp4_ptr1", WS'(r), WS'(4'b0110));
        retire(r);
        step(r); retire(r);

        // Requester 2 keeps colliding with requester 1 until forced priority kicks in
        valid_in = 4'b0111;
        preg_in[0] = PW'(20); preg_in[1] = PW'(21); preg_in[2] = PW'(21);
        data_in[2] = WS'(64'hE2);
        for (int c = 0; c < LIMIT; c++) begin
            data_in[0] = WS'(64'h100 + c); data_in[1] = WS'(64'h200 + c);
            step(r);
            chk("starve_lose", WS'(r[2]), WS'(0));
        end
        data_in[0] = WS'(64'h1FF); data_in[1] = WS'(64'h2FF);
        step(r);
        chk("starve_flag", WS'(m_starved), WS'(0));
        chk("starve_ready", WS'(r), WS'(4'b0101));
        chk("starve_port0_preg", WS'(bus.wr_preg[0]), WS'(21));
        chk("starve_port0_data", bus.wr_data[0], WS'(64'hE2));
        valid_in = '0;
        step(r);

        // All four target one register: one grant per cycle
        valid_in = 4'b1111;
        for (int i = 0; i < NREQ; i++) begin
            preg_in[i] = PW'(50); data_in[i] = WS'(64'hF0 + i);
        end
        for (int c = 0; c < NREQ; c++) begin
            step(r);
            chk("same_preg_one", WS'($countones(r)), WS'(1));
            retire(r);
        end
        step(r);

        // Reset in the middle of a burst drops pending writes at once
        valid_in = 4'b1111;
        for (int i = 0; i < NREQ; i++) begin
            preg_in[i] = PW'(30 + i); data_in[i] = WS'(64'h300 + i);
        end
        step(r); retire(r);
        chk("pre_rst_wr_en", WS'(bus.wr_en), WS'(2'b11));
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_wr_en", WS'(bus.wr_en), WS'(0));
        chk("mid_rst_ready", WS'(bus.req_ready), WS'(0));
        sb.delete();
        model_reset();
        push_zero();
        @(posedge clk); #1;
        chk("hold_rst_wr_en", WS'(bus.wr_en), WS'(0));
        rst = 1'b1;
        valid_in = 4'b1111;
        for (int i = 0; i < NREQ; i++) begin
            preg_in[i] = PW'(40 + i); data_in[i] = WS'(64'h400 + i);
        end
        step(r);
        chk("release_no_grant", WS'(r), WS'(0));
        step(r);
        chk("release_first", WS'(r), WS'(4'b0011));
        retire(r);
        step(r); retire(r);
        step(r);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
